mem_access_arbiter: RTL and testbench
=====================================

// Module: mem_access_arbiter
// PURPOSE
//  Shares the single 2048x32 program/data SRAM between the CPU fetch port and the debug unit.
//  Issues at most one access per cycle, with a 1-cycle grant handshake.
//  Writes are gated by debug mode. Read data is returned to the requester that issued the read.
//  Sits between the fetch stage / debug unit and the SRAM wrapper; drives its address, Datain1/2, Wr.
// PARAMETERS
//  ADDR_W         11   meaningful SRAM address bits (2048 words)
//  DATA_W         32   data word width
//  RD_LAT          1   SRAM read latency in cycles (address sampled at Clk edge)
//  MAX_DBG_BURST   4   max consecutive debug grants while a fetch request is pending (1..15)
// PORTS
//  Clk          in   1       single clock, all logic rising-edge
//  Rst_n        in   1       synchronous reset, active-low
//  dbg_mode     in   1       1 = debug unit active; SRAM writes permitted
//  fetch_req    in   1       fetch read request, held until granted
//  fetch_addr   in   32      fetch word address; only [ADDR_W-1:0] used
//  fetch_gnt    out  1       request accepted this cycle
//  fetch_rvalid out  1       fetch_rdata valid (1-cycle pulse)
//  fetch_rdata  out  DATA_W  read data for fetch
//  dbg_req      in   1       debug request, held until granted
//  dbg_we       in   1       1 = write, 0 = read
//  dbg_addr     in   32      debug word address; only [ADDR_W-1:0] used
//  dbg_wdata1   in   DATA_W  write data, port 1
//  dbg_wdata2   in   DATA_W  write data, port 2
//  dbg_gnt      out  1       debug request accepted this cycle
//  dbg_rvalid   out  1       dbg_rdata valid (1-cycle pulse)
//  dbg_rdata    out  DATA_W  read data for debug
//  dbg_err      out  1       1-cycle pulse: write rejected (dbg_mode=0)
//  mem_address  out  32      to SRAM; {zeros, granted addr[ADDR_W-1:0]}
//  mem_Datain1  out  DATA_W  to SRAM port 1 write data
//  mem_Datain2  out  DATA_W  to SRAM port 2 write data
//  mem_Wr       out  1       SRAM write enable
//  mem_Dataout  in   DATA_W  SRAM read data
// BEHAVIOUR
//  Reset (Rst_n=0 at edge):
//   - All gnt/rvalid/err/mem_Wr = 0; mem_address = 0; mem_Datain1/2 = 0; rdata = 0.
//   - dbg_streak = 0; tag pipeline cleared; FSM -> NORMAL.
//   - In-flight reads are discarded: no rvalid after reset.
//  Grants are combinational from registered state and current req; one gnt max per cycle.
//   - gnt=1 => request consumed at that edge.
//   - mem_address/mem_Wr/mem_Datain driven combinationally in the grant cycle.
//  FSM (registered, updated each edge):
//   - NORMAL: entered from DRAIN with pipe empty and dbg_mode=0.
//     - fetch priority: debug granted only if fetch_req=0.
//     - Debug write in NORMAL: granted, mem_Wr=0, dbg_err=1 next cycle.
//     - dbg_mode=1 -> DEBUG.
//   - DEBUG:
//     - Debug priority over fetch, except when dbg_streak==MAX_DBG_BURST; then fetch wins.
//     - dbg_streak: +1 per debug grant while fetch_req=1; cleared on fetch grant or fetch_req=0.
//     - Saturates at MAX_DBG_BURST.
//     - dbg_mode=0 -> DRAIN.
//   - DRAIN: no grants to either port until the read tag pipe is empty.
//     - Then -> NORMAL, or -> DEBUG if dbg_mode=1 again.
//  Writes: mem_Wr=1 only in DEBUG grant cycle with dbg_we=1.
//   - Data1 -> addr, Data2 -> addr+1; the SRAM wraps address 2047 -> 0.
//   - Writes produce no rvalid.
//  Reads: RD_LAT-deep shift register of {valid, owner} per grant.
//   - Exactly RD_LAT cycles after the grant, the owner gets rvalid=1 and rdata=mem_Dataout (registered).
//   - The other port's rvalid stays 0; rdata holds its last value otherwise.
//  Address bits [31:ADDR_W] are ignored (aliasing); no error flagged.
//  Back-to-back grants every cycle are allowed: throughput 1 access/cycle.
// TESTING
//  1. Reset: hold Rst_n=0 with both reqs=1 -> all outputs 0, no gnt.
//     Release -> fetch_gnt in first cycle (NORMAL).
//  2. NORMAL fetch read addr 0x10 (mem holds 0xDEADBEEF) -> fetch_gnt cyc0.
//     fetch_rvalid=1, fetch_rdata=0xDEADBEEF at cyc0+RD_LAT.
//  3. dbg_mode=0, debug write addr 5 -> dbg_gnt=1, mem_Wr=0, dbg_err pulse next cycle, SRAM unchanged.
//  4. DEBUG, both reqs held continuously, MAX_DBG_BURST=4 -> grant pattern D,D,D,D,F repeating.
//  5. DEBUG write addr 2047, d1=0xA, d2=0xB -> mem_Wr=1 one cycle.
//     Subsequent reads return addr2047=0xA and addr0=0xB.
//  6. Issue debug read, drop dbg_mode the same cycle -> DRAIN.
//     dbg_rvalid still delivered; no gnt until pipe empty.
//     Assert Rst_n=0 during a pending read -> no rvalid.

Source files
------------

// File: rtl/mem_access_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access_arbiter
//  Description : Shares one 2048x32 program/data SRAM between the CPU fetch
//                port and the debug unit. At most one access per cycle, with a
//                combinational grant. Writes are only performed in debug
//                mode. Read data is routed back to the port that issued it.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_access_arbiter #(
    parameter int ADDR_W        = 11,
    parameter int DATA_W        = 32,
    parameter int RD_LAT        = 1,
    parameter int MAX_DBG_BURST = 4
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              dbg_mode,
    // fetch port
    input  logic              fetch_req,
    input  logic [31:0]       fetch_addr,
    output logic              fetch_gnt,
    output logic              fetch_rvalid,
    output logic [DATA_W-1:0] fetch_rdata,
    // debug port
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [31:0]       dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata1,
    input  logic [DATA_W-1:0] dbg_wdata2,
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              dbg_err,
    // SRAM side
    output logic [31:0]       mem_address,
    output logic [DATA_W-1:0] mem_Datain1,
    output logic [DATA_W-1:0] mem_Datain2,
    output logic              mem_Wr,
    input  logic [DATA_W-1:0] mem_Dataout
);

    // Streak counter is 4 bits wide: MAX_DBG_BURST is limited to 1..15.
    localparam logic [3:0] c_MAX_STREAK = 4'(MAX_DBG_BURST);

    typedef enum logic [1:0] {
        ST_NORMAL = 2'd0,
        ST_DEBUG  = 2'd1,
        ST_DRAIN  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [3:0]        r_dbg_streak;
    logic [3:0]        w_streak_nxt;

    // Read tag pipeline: one {valid, owner} entry per stage, owner 1 = debug.
    logic [RD_LAT-1:0] r_pipe_vld;
    logic [RD_LAT-1:0] r_pipe_own;
    logic              w_pipe_empty;
    logic              w_out_vld;
    logic              w_out_own;

    logic              w_fetch_gnt;
    logic              w_dbg_gnt;
    logic              w_burst_cap;
    logic              w_wr_en;
    logic              w_rd_issue;
    logic [ADDR_W-1:0] w_sel_addr;

    logic [DATA_W-1:0] r_fetch_rdata;
    logic [DATA_W-1:0] r_dbg_rdata;
    logic              r_dbg_err;

    // Upper address bits alias onto the SRAM and are intentionally dropped.
    logic              w_unused_addr_hi;
    assign w_unused_addr_hi = ^{fetch_addr[31:ADDR_W], dbg_addr[31:ADDR_W]};

    assign w_pipe_empty = ~|r_pipe_vld;
    assign w_out_vld    = r_pipe_vld[RD_LAT-1];
    assign w_out_own    = r_pipe_own[RD_LAT-1];
    assign w_burst_cap  = (r_dbg_streak == c_MAX_STREAK);

    // Grant decision from the registered mode and the live requests.
    always_comb begin
        w_fetch_gnt = 1'b0;
        w_dbg_gnt   = 1'b0;
        if (Rst_n) begin
            case (r_state)
                ST_NORMAL: begin
                    if (fetch_req) begin
                        w_fetch_gnt = 1'b1;
                    end else if (dbg_req) begin
                        w_dbg_gnt = 1'b1;
                    end
                end
                ST_DEBUG: begin
                    // Debug wins unless it has starved a waiting fetch too long.
                    if (dbg_req && !(fetch_req && w_burst_cap)) begin
                        w_dbg_gnt = 1'b1;
                    end else if (fetch_req) begin
                        w_fetch_gnt = 1'b1;
                    end
                end
                default: begin
                    // DRAIN: hold off all traffic until outstanding reads return.
                end
            endcase
        end
    end

    // Mode transitions.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_NORMAL: if (dbg_mode)  w_state_nxt = ST_DEBUG;
            ST_DEBUG:  if (!dbg_mode) w_state_nxt = ST_DRAIN;
            ST_DRAIN: begin
                if (w_pipe_empty) begin
                    w_state_nxt = dbg_mode ? ST_DEBUG : ST_NORMAL;
                end
            end
            default:   w_state_nxt = ST_NORMAL;
        endcase
    end

    // Debug streak: counts debug grants that bypassed a waiting fetch.
    always_comb begin
        w_streak_nxt = r_dbg_streak;
        if (w_fetch_gnt || !fetch_req) begin
            w_streak_nxt = 4'd0;
        end else if (w_dbg_gnt && !w_burst_cap) begin
            w_streak_nxt = r_dbg_streak + 4'd1;
        end
    end

    // Mode and streak registers.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            r_state      <= ST_NORMAL;
            r_dbg_streak <= 4'd0;
        end else begin
            r_state      <= w_state_nxt;
            r_dbg_streak <= w_streak_nxt;
        end
    end

    assign w_wr_en    = w_dbg_gnt && dbg_we && (r_state == ST_DEBUG);
    assign w_rd_issue = w_fetch_gnt || (w_dbg_gnt && !dbg_we);
    assign w_sel_addr = w_dbg_gnt ? dbg_addr[ADDR_W-1:0] : fetch_addr[ADDR_W-1:0];

    generate
        if (RD_LAT == 1) begin : g_pipe_single
            // Single-stage tag register matching a one-cycle SRAM read.
            always_ff @(posedge Clk) begin
                if (!Rst_n) begin
                    r_pipe_vld <= '0;
                    r_pipe_own <= '0;
                end else begin
                    r_pipe_vld <= w_rd_issue;
                    r_pipe_own <= w_dbg_gnt;
                end
            end
        end else begin : g_pipe_multi
            // Multi-stage tag shift register, one stage per SRAM latency cycle.
            always_ff @(posedge Clk) begin
                if (!Rst_n) begin
                    r_pipe_vld <= '0;
                    r_pipe_own <= '0;
                end else begin
                    r_pipe_vld <= {r_pipe_vld[RD_LAT-2:0], w_rd_issue};
                    r_pipe_own <= {r_pipe_own[RD_LAT-2:0], w_dbg_gnt};
                end
            end
        end
    endgenerate

    // Capture returned read data so each port holds its last value.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            r_fetch_rdata <= '0;
            r_dbg_rdata   <= '0;
        end else if (w_out_vld) begin
            if (w_out_own) begin
                r_dbg_rdata <= mem_Dataout;
            end else begin
                r_fetch_rdata <= mem_Dataout;
            end
        end
    end

    // Rejected-write flag, reported one cycle after the grant.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            r_dbg_err <= 1'b0;
        end else begin
            r_dbg_err <= w_dbg_gnt && dbg_we && (r_state != ST_DEBUG);
        end
    end

    assign fetch_gnt    = w_fetch_gnt;
    assign dbg_gnt      = w_dbg_gnt;
    assign dbg_err      = r_dbg_err;

    assign fetch_rvalid = w_out_vld && !w_out_own;
    assign dbg_rvalid   = w_out_vld &&  w_out_own;
    assign fetch_rdata  = fetch_rvalid ? mem_Dataout : r_fetch_rdata;
    assign dbg_rdata    = dbg_rvalid   ? mem_Dataout : r_dbg_rdata;

    assign mem_address  = (w_fetch_gnt || w_dbg_gnt) ? 32'(w_sel_addr) : 32'd0;
    assign mem_Wr       = w_wr_en;
    assign mem_Datain1  = w_dbg_gnt ? dbg_wdata1 : '0;
    assign mem_Datain2  = w_dbg_gnt ? dbg_wdata2 : '0;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_access_arbiter
//  Description : Self-checking bench for mem_access_arbiter with an SRAM
//                stand-in and a behavioural reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_arbiter;

    localparam int ADDR_W        = 11;
    localparam int DATA_W        = 32;
    localparam int RD_LAT        = 1;
    localparam int MAX_DBG_BURST = 4;
    localparam int DEPTH         = 2048;

    logic              Clk = 1'b0;
    logic              Rst_n;
    logic              dbg_mode;
    logic              fetch_req;
    logic [31:0]       fetch_addr;
    logic              fetch_gnt;
    logic              fetch_rvalid;
    logic [DATA_W-1:0] fetch_rdata;
    logic              dbg_req;
    logic              dbg_we;
    logic [31:0]       dbg_addr;
    logic [DATA_W-1:0] dbg_wdata1;
    logic [DATA_W-1:0] dbg_wdata2;
    logic              dbg_gnt;
    logic              dbg_rvalid;
    logic [DATA_W-1:0] dbg_rdata;
    logic              dbg_err;
    logic [31:0]       mem_address;
    logic [DATA_W-1:0] mem_Datain1;
    logic [DATA_W-1:0] mem_Datain2;
    logic              mem_Wr;
    logic [DATA_W-1:0] mem_Dataout;

    always #5 Clk = ~Clk;

    mem_access_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT), .MAX_DBG_BURST(MAX_DBG_BURST)
    ) dut (
        .Clk(Clk), .Rst_n(Rst_n), .dbg_mode(dbg_mode),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_gnt(fetch_gnt),
        .fetch_rvalid(fetch_rvalid), .fetch_rdata(fetch_rdata),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
        .dbg_wdata1(dbg_wdata1), .dbg_wdata2(dbg_wdata2), .dbg_gnt(dbg_gnt),
        .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata), .dbg_err(dbg_err),
        .mem_address(mem_address), .mem_Datain1(mem_Datain1), .mem_Datain2(mem_Datain2),
        .mem_Wr(mem_Wr), .mem_Dataout(mem_Dataout)
    );

    // SRAM contents as seen by the DUT, and the model's own copy.
    logic [DATA_W-1:0] sram    [DEPTH];
    logic [DATA_W-1:0] ref_mem [DEPTH];

    // Reference model state: 0 = normal, 1 = debug, 2 = drain.
    typedef struct {
        int          due;
        bit          own_dbg;
        logic [31:0] data;
    } rsp_t;
    rsp_t        rsp_q[$];
    int          mode;
    int          streak;
    int          cyc;
    bit          g_f, g_d;
    logic [31:0] exp_frd, exp_drd;
    bit          exp_err;

    // Observed values of the last cycle, for directed checks.
    logic [1:0]  last_pat;
    logic        last_wr, last_err, last_frv, last_drv;
    logic [31:0] last_frd, last_drd;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] init_val(input int i);
        return 32'(i) * 32'h0001_0003 ^ 32'h5A5A_0000;
    endfunction

    function automatic logic [31:0] rand_addr();
        logic [31:0]       a;
        logic [ADDR_W-1:0] lo;
        int                k;
        k = $urandom_range(0, 7);
        case (k)
            0:       lo = 11'd0;
            1:       lo = 11'd1;
            2:       lo = 11'd2;
            3:       lo = 11'd2046;
            4:       lo = 11'd2047;
            5:       lo = 11'd16;
            default: lo = ADDR_W'($urandom);
        endcase
        a = $urandom;
        if ($urandom_range(0, 1) == 0) a = '0;
        a[ADDR_W-1:0] = lo;
        return a;
    endfunction

    // One clock cycle: check at the falling edge, advance model at the rising edge.
    task automatic cycle();
        bit                due_f, due_d, exp_wr, busy;
        logic [31:0]       due_data;
        logic [ADDR_W-1:0] s_addr, s_a1;
        logic              s_wr;
        logic [31:0]       s_d1, s_d2;
        int                a;
        rsp_t              r;

        @(negedge Clk);
        g_f = 1'b0;
        g_d = 1'b0;
        if (Rst_n) begin
            if (mode == 0) begin
                if (fetch_req) g_f = 1'b1;
                else if (dbg_req) g_d = 1'b1;
            end else if (mode == 1) begin
                if (dbg_req && !(fetch_req && streak == MAX_DBG_BURST)) g_d = 1'b1;
                else if (fetch_req) g_f = 1'b1;
            end
        end
        exp_wr   = g_d && dbg_we && (mode == 1);
        due_f    = 1'b0;
        due_d    = 1'b0;
        due_data = '0;
        if (rsp_q.size() > 0 && rsp_q[0].due == cyc) begin
            if (rsp_q[0].own_dbg) due_d = 1'b1;
            else                  due_f = 1'b1;
            due_data = rsp_q[0].data;
        end

        check("fetch_gnt", 32'(fetch_gnt), 32'(g_f));
        check("dbg_gnt",   32'(dbg_gnt),   32'(g_d));
        check("mem_Wr",    32'(mem_Wr),    32'(exp_wr));
        if (g_f || g_d)
            check("mem_address", mem_address,
                  32'(g_d ? dbg_addr[ADDR_W-1:0] : fetch_addr[ADDR_W-1:0]));
        if (exp_wr) begin
            check("mem_Datain1", mem_Datain1, dbg_wdata1);
            check("mem_Datain2", mem_Datain2, dbg_wdata2);
        end
        if (!Rst_n) begin
            check("rst_mem_address", mem_address, 32'd0);
            check("rst_mem_Datain1", mem_Datain1, 32'd0);
            check("rst_mem_Datain2", mem_Datain2, 32'd0);
        end
        check("fetch_rvalid", 32'(fetch_rvalid), 32'(due_f));
        check("dbg_rvalid",   32'(dbg_rvalid),   32'(due_d));
        check("fetch_rdata",  fetch_rdata, due_f ? due_data : exp_frd);
        check("dbg_rdata",    dbg_rdata,   due_d ? due_data : exp_drd);
        check("dbg_err",      32'(dbg_err),      32'(exp_err));

        last_pat = {fetch_gnt, dbg_gnt};
        last_wr  = mem_Wr;
        last_err = dbg_err;
        last_frv = fetch_rvalid;
        last_drv = dbg_rvalid;
        last_frd = fetch_rdata;
        last_drd = dbg_rdata;
        s_addr   = mem_address[ADDR_W-1:0];
        s_a1     = s_addr + 1'b1;
        s_wr     = mem_Wr;
        s_d1     = mem_Datain1;
        s_d2     = mem_Datain2;

        @(posedge Clk);
        // SRAM stand-in: address sampled at the edge, data out one cycle later.
        mem_Dataout <= sram[s_addr];
        if (s_wr) begin
            sram[s_addr] = s_d1;
            sram[s_a1]   = s_d2;
        end

        if (!Rst_n) begin
            mode    = 0;
            streak  = 0;
            rsp_q.delete();
            exp_frd = '0;
            exp_drd = '0;
            exp_err = 1'b0;
        end else begin
            busy = (rsp_q.size() > 0);
            if (due_f) exp_frd = due_data;
            if (due_d) exp_drd = due_data;
            if (due_f || due_d) void'(rsp_q.pop_front());
            a = g_d ? int'(dbg_addr[ADDR_W-1:0]) : int'(fetch_addr[ADDR_W-1:0]);
            if (g_f || (g_d && !dbg_we)) begin
                r.due     = cyc + RD_LAT;
                r.own_dbg = g_d;
                r.data    = ref_mem[a];
                rsp_q.push_back(r);
            end
            if (exp_wr) begin
                ref_mem[a]               = dbg_wdata1;
                ref_mem[(a + 1) % DEPTH] = dbg_wdata2;
            end
            exp_err = g_d && dbg_we && (mode != 1);
            if (g_f || !fetch_req)                     streak = 0;
            else if (g_d && streak < MAX_DBG_BURST)    streak = streak + 1;
            if (mode == 0 && dbg_mode)                 mode = 1;
            else if (mode == 1 && !dbg_mode)           mode = 2;
            else if (mode == 2 && !busy)               mode = dbg_mode ? 1 : 0;
        end
        cyc++;
        #1;
    endtask

    // Random traffic obeying the hold-until-granted protocol.
    task automatic rand_drive();
        if (!fetch_req || g_f) begin
            fetch_req  = ($urandom_range(0, 3) != 0);
            fetch_addr = rand_addr();
        end
        if (!dbg_req || g_d) begin
            dbg_req    = ($urandom_range(0, 2) != 0);
            dbg_we     = ($urandom_range(0, 2) == 0);
            dbg_addr   = rand_addr();
            dbg_wdata1 = $urandom;
            dbg_wdata2 = $urandom;
        end
        if ($urandom_range(0, 24) == 0) dbg_mode = ~dbg_mode;
        Rst_n = ($urandom_range(0, 199) != 0);
    endtask

    logic [9:0] pat;

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            sram[i]    = init_val(i);
            ref_mem[i] = init_val(i);
        end
        sram[16]    = 32'hDEAD_BEEF;
        ref_mem[16] = 32'hDEAD_BEEF;
        mem_Dataout <= '0;
        mode = 0; streak = 0; cyc = 0;
        exp_frd = '0; exp_drd = '0; exp_err = 1'b0;
        g_f = 1'b0; g_d = 1'b0;

        Rst_n = 1'b0; dbg_mode = 1'b0;
        fetch_req = 1'b1; fetch_addr = 32'h10;
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h3;
        dbg_wdata1 = '0; dbg_wdata2 = '0;
        repeat (2) @(posedge Clk);
        #1;

        // 1. reset with both requests held, then release
        repeat (3) begin
            cycle();
            check("t1_rst_no_gnt", 32'(last_pat), 32'd0);
        end
        Rst_n = 1'b1;
        cycle();
        check("t1_first_fetch_gnt", 32'(last_pat), 32'd2);

        // 2. fetch read of 0x10 returns DEADBEEF one cycle later
        fetch_req = 1'b0; dbg_req = 1'b0;
        cycle();
        check("t2_fetch_rvalid", 32'(last_frv), 32'd1);
        check("t2_fetch_rdata",  last_frd, 32'hDEAD_BEEF);

        // 3. debug write outside debug mode is rejected
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 32'd5; dbg_wdata1 = 32'h5555_0001;
        cycle();
        check("t3_dbg_gnt", 32'(last_pat), 32'd1);
        check("t3_no_wr",   32'(last_wr),  32'd0);
        dbg_req = 1'b0; dbg_we = 1'b0;
        cycle();
        check("t3_err_pulse",  32'(last_err), 32'd1);
        check("t3_sram_kept",  sram[5], init_val(5));
        cycle();
        check("t3_err_cleared", 32'(last_err), 32'd0);

        // 4. debug mode, both held: D,D,D,D,F repeating
        dbg_mode = 1'b1;
        cycle();
        fetch_req = 1'b1; fetch_addr = 32'd1;
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'd3;
        pat = '0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            pat = {pat[8:0], (last_pat == 2'b01)};
        end
        check("t4_burst_pattern", 32'(pat), 32'(10'b1111011110));

        // 5. wrapping write at 2047 (aliased address), then read both words
        fetch_req = 1'b0;
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 32'hFFFF_FFFF;
        dbg_wdata1 = 32'hA; dbg_wdata2 = 32'hB;
        cycle();
        check("t5_wr", 32'(last_wr), 32'd1);
        dbg_we = 1'b0; dbg_addr = 32'd2047;
        cycle();
        check("t5_sram2047", sram[2047], 32'hA);
        check("t5_sram0",    sram[0],    32'hB);
        dbg_addr = 32'd0;
        cycle();
        check("t5_rd2047_valid", 32'(last_drv), 32'd1);
        check("t5_rd2047",       last_drd, 32'hA);
        dbg_req = 1'b0;
        cycle();
        check("t5_rd0", last_drd, 32'hB);

        // 6. debug read while leaving debug mode, then drain
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'd7; dbg_mode = 1'b0;
        cycle();
        check("t6_dbg_gnt", 32'(last_pat), 32'd1);
        dbg_req = 1'b0; fetch_req = 1'b1; fetch_addr = 32'd2;
        cycle();
        check("t6_drain_rvalid", 32'(last_drv), 32'd1);
        check("t6_drain_rdata",  last_drd, ref_mem[7]);
        check("t6_drain_no_gnt", 32'(last_pat), 32'd0);
        cycle();
        check("t6_drain_no_gnt2", 32'(last_pat), 32'd0);
        cycle();
        check("t6_normal_fetch", 32'(last_pat), 32'd2);

        // reset while a read is in flight: nothing comes back afterwards
        fetch_addr = 32'd16; Rst_n = 1'b0;
        cycle();
        check("t6_rst_no_gnt", 32'(last_pat), 32'd0);
        Rst_n = 1'b1; fetch_req = 1'b0;
        cycle();
        check("t6_rst_no_rvalid", 32'(last_frv), 32'd0);
        check("t6_rst_rdata",     last_frd, 32'd0);

        // randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            rand_drive();
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
